// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the unified-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_FPGA = 1'b1
    } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's link to the arbiter: request fields in, ack/err/rdata back.
// Latency: wires only.
// Backpressure: req is held with stable fields until the one-cycle ack.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wen, addr, wdata, input ack, err, rdata);
    modport slave  (input req, wen, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick; a locked FPGA that won last keeps winning.
// Latency: combinational.
// Backpressure: none; winner is meaningless when req == 0.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,     // [0] = CPU, [1] = FPGA
    input  owner_e     last,
    input  logic       lock,
    output owner_e     winner
);

    // Pick the sole requester, else whoever was not granted last (unless locked).
    always_comb begin
        winner = OWN_CPU;
        case (req)
            2'b01: winner = OWN_CPU;
            2'b10: winner = OWN_FPGA;
            2'b11: begin
                if (lock && (last == OWN_FPGA)) begin
                    winner = OWN_FPGA;
                end else begin
                    winner = (last == OWN_CPU) ? OWN_FPGA : OWN_CPU;
                end
            end
            default: winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM between the CPU and FPGA requesters, one access at a time.
// Latency: 2 cycles from request sample to ack, plus one per busy cycle (abort after TIMEOUT).
// Backpressure: requesters hold req until ack; RAM stalls the access via ram_busy.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset,
    ram_arbiter_if.slave      cpu,
    ram_arbiter_if.slave      fpga,
    input  logic              fpga_lock,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy,
    output logic              owner_fpga
);

    // Wide enough to hold TIMEOUT itself, so the count saturates instead of wrapping.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state, state_nxt;
    owner_e            owner, last_grant, winner;
    logic              any_req;
    logic              timed_out;
    logic              hold_wen;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [CNT_W-1:0]  cnt;
    logic              cpu_err_q, fpga_err_q;
    logic [DATA_W-1:0] cpu_rdata_q, fpga_rdata_q;

    assign any_req   = cpu.req | fpga.req;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    rr_arb2 u_rr_arb2 (
        .req    ({fpga.req, cpu.req}),
        .last   (last_grant),
        .lock   (fpga_lock),
        .winner (winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, wait out busy in ACCESS, ack for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = ACCESS;
            ACCESS:   if (!ram_busy || timed_out) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request, count busy cycles, capture results.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= OWN_CPU;
            last_grant   <= OWN_FPGA;
            hold_wen     <= 1'b0;
            hold_addr    <= '0;
            hold_wdata   <= '0;
            cnt          <= '0;
            cpu_err_q    <= 1'b0;
            fpga_err_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            fpga_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        hold_wen   <= (winner == OWN_FPGA) ? fpga.wen   : cpu.wen;
                        hold_addr  <= (winner == OWN_FPGA) ? fpga.addr  : cpu.addr;
                        hold_wdata <= (winner == OWN_FPGA) ? fpga.wdata : cpu.wdata;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    if (!ram_busy) begin
                        if (owner == OWN_FPGA) begin
                            fpga_err_q <= 1'b0;
                            if (!hold_wen) fpga_rdata_q <= ram_rdata;
                        end else begin
                            cpu_err_q <= 1'b0;
                            if (!hold_wen) cpu_rdata_q <= ram_rdata;
                        end
                    end else if (timed_out) begin
                        if (owner == OWN_FPGA) fpga_err_q <= 1'b1;
                        else                   cpu_err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMPLETE: last_grant <= owner;
                default: ;
            endcase
        end
    end

    // RAM address/data hold their last values; write strobe only while accessing.
    assign ram_wen    = (state == ACCESS) && hold_wen;
    assign ram_addr   = hold_addr;
    assign ram_wdata  = hold_wdata;
    assign owner_fpga = (state != IDLE) && (owner == OWN_FPGA);

    assign cpu.ack    = (state == COMPLETE) && (owner == OWN_CPU);
    assign fpga.ack   = (state == COMPLETE) && (owner == OWN_FPGA);
    assign cpu.err    = cpu_err_q;
    assign fpga.err   = fpga_err_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign fpga.rdata = fpga_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with TIMEOUT = 8.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fpga_lock;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;
    logic        owner_fpga;

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fpga_if ();

    ram_arbiter #(.TIMEOUT(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_if),
        .fpga       (fpga_if),
        .fpga_lock  (fpga_lock),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_busy   (ram_busy),
        .owner_fpga (owner_fpga)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        fpga_lock     = 1'b0;
        ram_rdata     = 32'h0;
        ram_busy      = 1'b0;
        cpu_if.req    = 1'b0; cpu_if.wen  = 1'b0; cpu_if.addr  = 32'h0; cpu_if.wdata  = 32'h0;
        fpga_if.req   = 1'b0; fpga_if.wen = 1'b0; fpga_if.addr = 32'h0; fpga_if.wdata = 32'h0;
        tick();
        tick();
        check1 ("rst_cpu_ack",   cpu_if.ack,   1'b0);
        check1 ("rst_fpga_ack",  fpga_if.ack,  1'b0);
        check1 ("rst_cpu_err",   cpu_if.err,   1'b0);
        check1 ("rst_ram_wen",   ram_wen,      1'b0);
        check1 ("rst_owner",     owner_fpga,   1'b0);
        check32("rst_ram_addr",  ram_addr,     32'h0);
        check32("rst_ram_wdata", ram_wdata,    32'h0);
        check32("rst_cpu_rdata", cpu_if.rdata, 32'h0);
        reset = 1'b0;

        // Single CPU read: sampled at cycle 0, ack at cycle 2.
        cpu_if.req = 1'b1; cpu_if.wen = 1'b0; cpu_if.addr = 32'h10;
        ram_rdata  = 32'hDEADBEEF;
        tick();
        check1 ("rd_c1_wen",   ram_wen,    1'b0);
        check32("rd_c1_addr",  ram_addr,   32'h10);
        check1 ("rd_c1_ack",   cpu_if.ack, 1'b0);
        tick();
        check1 ("rd_c2_ack",   cpu_if.ack,   1'b1);
        check1 ("rd_c2_err",   cpu_if.err,   1'b0);
        check32("rd_c2_rdata", cpu_if.rdata, 32'hDEADBEEF);
        check1 ("rd_c2_wen",   ram_wen,      1'b0);
        cpu_if.req = 1'b0;
        tick();
        check1 ("rd_c3_ack",   cpu_if.ack,   1'b0);

        // Simultaneous requests after a fresh reset: CPU wins the first tie.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check32("rst2_cpu_rdata", cpu_if.rdata, 32'h0);
        cpu_if.req  = 1'b1; cpu_if.wen  = 1'b1; cpu_if.addr  = 32'h4; cpu_if.wdata = 32'h1234;
        fpga_if.req = 1'b1; fpga_if.wen = 1'b0; fpga_if.addr = 32'h8;
        ram_rdata   = 32'hCAFEF00D;
        tick();
        check1 ("sim_c1_wen",   ram_wen,    1'b1);
        check32("sim_c1_wdata", ram_wdata,  32'h1234);
        check32("sim_c1_addr",  ram_addr,   32'h4);
        check1 ("sim_c1_owner", owner_fpga, 1'b0);
        tick();
        check1 ("sim_c2_cack",  cpu_if.ack,  1'b1);
        check1 ("sim_c2_fack",  fpga_if.ack, 1'b0);
        check1 ("sim_c2_wen",   ram_wen,     1'b0);
        cpu_if.req = 1'b0; cpu_if.wen = 1'b0;
        tick();
        check1 ("sim_c3_fack",  fpga_if.ack, 1'b0);
        tick();
        check1 ("sim_c4_owner", owner_fpga,  1'b1);
        check32("sim_c4_addr",  ram_addr,    32'h8);
        check1 ("sim_c4_wen",   ram_wen,     1'b0);
        tick();
        check1 ("sim_c5_fack",  fpga_if.ack,   1'b1);
        check32("sim_c5_rdata", fpga_if.rdata, 32'hCAFEF00D);
        check32("sim_c5_crd",   cpu_if.rdata,  32'h0);

        // FPGA lock: four FPGA writes back to back while the CPU waits.
        fpga_lock     = 1'b1;
        fpga_if.wen   = 1'b1; fpga_if.addr = 32'h100; fpga_if.wdata = 32'hA0;
        cpu_if.req    = 1'b1; cpu_if.wen   = 1'b0;    cpu_if.addr   = 32'h20;
        ram_rdata     = 32'h5555AAAA;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check1 ("lock_owner", owner_fpga, 1'b1);
            check1 ("lock_wen",   ram_wen,    1'b1);
            check32("lock_addr",  ram_addr,   32'h100 + 32'(4 * i));
            check32("lock_wdata", ram_wdata,  32'hA0 + 32'(i));
            tick();
            check1 ("lock_fack",  fpga_if.ack, 1'b1);
            check1 ("lock_cack",  cpu_if.ack,  1'b0);
            fpga_if.addr  = 32'h100 + 32'(4 * (i + 1));
            fpga_if.wdata = 32'hA0 + 32'(i + 1);
            if (i == 3) fpga_lock = 1'b0;
            tick();
            check1 ("lock_idle_cack", cpu_if.ack, 1'b0);
        end
        tick();
        check1 ("unlock_owner", owner_fpga, 1'b0);
        check32("unlock_addr",  ram_addr,   32'h20);
        check1 ("unlock_wen",   ram_wen,    1'b0);
        tick();
        check1 ("unlock_cack",  cpu_if.ack,   1'b1);
        check1 ("unlock_fack",  fpga_if.ack,  1'b0);
        check32("unlock_rdata", cpu_if.rdata, 32'h5555AAAA);
        cpu_if.req = 1'b0;
        tick();
        tick();
        check1 ("f5_owner", owner_fpga, 1'b1);
        check32("f5_addr",  ram_addr,   32'h110);
        check32("f5_wdata", ram_wdata,  32'hA4);
        tick();
        check1 ("f5_fack",  fpga_if.ack, 1'b1);
        fpga_if.req = 1'b0; fpga_if.wen = 1'b0;
        tick();

        // Busy stretch: five busy ACCESS cycles, ack at cycle 7.
        fpga_if.req = 1'b1; fpga_if.wen = 1'b0; fpga_if.addr = 32'h40;
        ram_busy    = 1'b1;
        ram_rdata   = 32'h11111111;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check1 ("busy_wait_ack", fpga_if.ack, 1'b0);
        end
        tick();
        ram_busy  = 1'b0;
        ram_rdata = 32'h0BADCAFE;
        check1 ("busy_c6_ack",   fpga_if.ack, 1'b0);
        check1 ("busy_c6_owner", owner_fpga,  1'b1);
        tick();
        ram_rdata = 32'h22222222;
        check1 ("busy_c7_ack",   fpga_if.ack,   1'b1);
        check1 ("busy_c7_err",   fpga_if.err,   1'b0);
        check32("busy_c7_rdata", fpga_if.rdata, 32'h0BADCAFE);
        fpga_if.req = 1'b0;
        tick();

        // Timeout with TIMEOUT = 8: ack with err at cycle 10, rdata kept.
        cpu_if.req = 1'b1; cpu_if.wen = 1'b0; cpu_if.addr = 32'h80;
        ram_busy   = 1'b1;
        ram_rdata  = 32'h99999999;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check1 ("to_wait_ack", cpu_if.ack, 1'b0);
        end
        tick();
        check1 ("to_c10_ack",   cpu_if.ack,   1'b1);
        check1 ("to_c10_err",   cpu_if.err,   1'b1);
        check32("to_c10_rdata", cpu_if.rdata, 32'h5555AAAA);
        ram_busy    = 1'b0;
        cpu_if.addr = 32'h84;
        ram_rdata   = 32'h12345678;
        tick();
        check1 ("to_next_idle", cpu_if.ack, 1'b0);
        tick();
        check32("to_next_addr", ram_addr, 32'h84);
        tick();
        check1 ("to_next_ack",   cpu_if.ack,   1'b1);
        check1 ("to_next_err",   cpu_if.err,   1'b0);
        check32("to_next_rdata", cpu_if.rdata, 32'h12345678);
        cpu_if.req = 1'b0;
        tick();

        // Reset in the middle of a CPU write.
        cpu_if.req = 1'b1; cpu_if.wen = 1'b1; cpu_if.addr = 32'hC0; cpu_if.wdata = 32'hAB;
        tick();
        check1 ("rstw_c1_wen", ram_wen, 1'b1);
        reset       = 1'b1;
        fpga_if.req = 1'b1; fpga_if.wen = 1'b0; fpga_if.addr = 32'hD0;
        tick();
        reset = 1'b0;
        check1 ("rstw_wen",   ram_wen,     1'b0);
        check1 ("rstw_cack",  cpu_if.ack,  1'b0);
        check1 ("rstw_fack",  fpga_if.ack, 1'b0);
        check1 ("rstw_owner", owner_fpga,  1'b0);
        check32("rstw_addr",  ram_addr,    32'h0);
        tick();
        check1 ("rstw_tie_owner", owner_fpga, 1'b0);
        check1 ("rstw_tie_wen",   ram_wen,    1'b1);
        check32("rstw_tie_addr",  ram_addr,   32'hC0);
        tick();
        check1 ("rstw_tie_cack",  cpu_if.ack, 1'b1);
        cpu_if.req = 1'b0; cpu_if.wen = 1'b0;
        ram_rdata  = 32'h77;
        tick();
        tick();
        check1 ("rstw_f_owner", owner_fpga, 1'b1);
        check32("rstw_f_addr",  ram_addr,   32'hD0);
        tick();
        check1 ("rstw_f_ack",   fpga_if.ack,   1'b1);
        check32("rstw_f_rdata", fpga_if.rdata, 32'h77);
        fpga_if.req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequential arbiter sharing the single-ported unified RAM between the CPU request unit and the FPGA calculator/debug front end, replacing the static `fpgaMemEnable` mux in the FPGA top. It latches one request at a time, drives the RAM port for it, and waits for the RAM `busy` to clear. It then returns read data with a one-cycle acknowledge to the winning requester. Arbitration is round-robin, with an optional FPGA lock for bulk loads and a busy timeout that reports an error.

## Interface
- `TIMEOUT`, 255: maximum ACCESS cycles with `ram_busy` high before the access is aborted.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU request; held high with stable fields until `cpu_ack`.
- `cpu_wen` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_ack`; 1 = timed out.
- `cpu_rdata` out DATA_W: registered read data, valid from `cpu_ack` until the next CPU completion.
- `fpga_req`, `fpga_wen`, `fpga_addr`, `fpga_wdata`, `fpga_ack`, `fpga_err`, `fpga_rdata`: same definitions, FPGA side.
- `fpga_lock` in 1: while high, the FPGA keeps priority once it has won.
- `ram_wen` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data.
- `ram_busy` in 1: RAM access in progress.
- `owner_fpga` out 1: 1 while the FPGA owns the port in ACCESS or COMPLETE.

## Operation
- States: IDLE, ACCESS, COMPLETE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner, latch its `wen`/`addr`/`wdata` into holding registers, clear the timeout counter, and go to ACCESS.
- **Winner selection**
  - Only one requester: it wins.
  - Both requesting: the requester not granted last wins.
  - Exception: if `fpga_lock`=1 and the last grant was FPGA, the FPGA wins.
- **ACCESS**
  - `ram_addr`/`ram_wdata` come from the holding registers; `ram_wen` = held `wen`.
  - When `ram_busy`=0: capture `ram_rdata` into the owner's `rdata` (reads only; writes leave `rdata` unchanged), set `err`=0, go to COMPLETE.
  - Otherwise increment the counter. When it reaches TIMEOUT: set owner `err`=1, leave `rdata` unchanged, go to COMPLETE.
- **COMPLETE**
  - The owner's `ack`=1, `ram_wen`=0, and no arbitration takes place.
  - Update the last-grant register, then go to IDLE.
- **Requester protocol**
  - A requester may drop `req` or present a new request in the cycle after `ack`.
  - Changing the request fields while `req` is high and un-acked is illegal; the arbiter uses the values latched in IDLE.
- **Idle RAM port:** outside ACCESS, `ram_addr`/`ram_wdata` hold their last values and `ram_wen`=0.
- **Lock:** `fpga_lock` while the CPU owns the port has no effect until the next arbitration.
- **Counter:** width is clog2(TIMEOUT+1); it must never wrap.

## Timing
- **Reset values:** state IDLE; all `ack`, `err`, `ram_wen`, `owner_fpga` = 0; `rdata`, `ram_addr`, `ram_wdata` = 0; last grant = FPGA, so the CPU wins the first tie.
- **Reset mid-access:** the access is abandoned with no `ack`; `ram_wen` drops in the cycle after reset is sampled.
- **Minimum latency:** request sampled in IDLE at cycle 0, ACCESS at cycle 1 (with `ram_busy`=0), `ack` at cycle 2, next arbitration at cycle 3. Throughput is one access per 3 cycles.
- **RAM busy:** each cycle `ram_busy` is high in ACCESS adds one cycle of latency, up to TIMEOUT. The timed-out `ack` arrives at cycle TIMEOUT+2.
- **Glitch-free outputs:** `ack`, `err`, `rdata`, `owner_fpga`, and all `ram_*` outputs are registered or decoded from registered state only; `ram_*` outputs are never combinational from `*_req`.

## Structure
- **Package `ram_arb_pkg`:** state enum {IDLE, ACCESS, COMPLETE}, owner enum {OWN_CPU, OWN_FPGA}, default width constants.
- **Sub-module `rr_arb2`:** combinational two-way round-robin pick with inputs `req[1:0]`, `last`, `lock`; output `winner`. Unit-tested separately.
- **Top-level change:** the FPGA top instantiates `ram_arbiter` between the request unit, the calculator and `ru_ram`, replacing the three muxes.

## Test plan
- **Single CPU read:** reset, `cpu_req`=1, `wen`=0, `addr`=0x10, `ram_rdata`=0xDEADBEEF, `busy`=0 → `cpu_ack` at cycle 2, `cpu_rdata`=0xDEADBEEF, `err`=0, `ram_wen` never high.
- **Simultaneous requests after reset:** CPU write 0x4 ← 0x1234, FPGA read 0x8 → CPU served first (`ram_wen`=1 for one ACCESS cycle, `ram_wdata`=0x1234), then FPGA `ack` at cycle 5.
- **FPGA lock:** `fpga_lock`=1, four back-to-back FPGA writes with `cpu_req` held high → four `fpga_ack`s at 3-cycle spacing with no `cpu_ack`. Drop the lock → the CPU is served next.
- **Busy stretch:** `ram_busy` high for 5 ACCESS cycles on an FPGA read → `fpga_ack` at cycle 7 with data sampled on the first cycle `busy`=0.
- **Timeout:** TIMEOUT=8, `ram_busy` stuck high → `cpu_ack` at cycle 10 with `cpu_err`=1 and `cpu_rdata` unchanged; the next request proceeds normally.
- **Reset during ACCESS:** assert `reset` for 1 cycle mid-write → `ram_wen`=0 the next cycle, no `ack`, state IDLE, the CPU wins the next tie.
